onehot_mux_skid: RTL

Parametrised successor to the writeback source-select mux: selects one of `NUM_IN` data channels using the team's zero-or-one-hot select encoding and registers the result behind a valid/ready handshake with a 2-entry skid buffer. The block flags illegal (multi-hot) selects per beat and keeps a saturating error count. It sits between the execute/memory result sources and the register-file write port, for pipelined core variants.

---
 rtl/onehot_mux_pkg.sv | 19 +
 rtl/onehot_mux_dec.sv | 35 +++
 rtl/onehot_mux_skid.sv | 127 ++++++++++++
 3 files changed

// File: rtl/onehot_mux_pkg.sv
// Shared types and helpers for the one-hot writeback source-select mux.
// Select legality is checked on a fixed 15-bit field, which is wide enough for 16 channels.
package onehot_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned SEL_MAX_W = 15;

    // Returns true when sel is zero or has exactly one bit set.
    function automatic logic sel_legal(input logic [SEL_MAX_W-1:0] sel);
        return (sel & (sel - SEL_MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_mux_dec.sv
// Combinational zero-or-one-hot channel select with an illegal-select flag.
// Reused without the skid stage by single-cycle cores.
module onehot_mux_dec
    import onehot_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 5,
    localparam int SEL_W  = NUM_IN - 1
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_err
);

    logic w_legal;

    assign w_legal = sel_legal(SEL_MAX_W'(i_sel));
    assign o_err   = !w_legal;

    // A zero select falls through to channel 0; illegal selects force zero data.
    always_comb begin
        o_data = i_data[WIDTH-1:0];
        if (!w_legal) begin
            o_data = '0;
        end else begin
            for (int unsigned i = 0; i < SEL_W; i++) begin
                if (i_sel[i]) begin
                    o_data = i_data[(i+1)*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/onehot_mux_skid.sv
// One-hot source-select mux registered behind a valid/ready handshake
// with a 2-entry skid buffer and a saturating illegal-select counter.
module onehot_mux_skid
    import onehot_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 5,
    localparam int SEL_W  = NUM_IN - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    err_count
);

    logic [WIDTH-1:0]     w_dec_data;
    logic                 w_dec_err;
    logic                 w_accept;
    logic                 w_deliver;
    logic                 w_ld_or_in;
    logic                 w_ld_or_sk;
    logic                 w_ld_sk;
    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_or_data;
    logic                 r_or_err;
    logic [WIDTH-1:0]     r_sk_data;
    logic                 r_sk_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    onehot_mux_dec #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_dec (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_dec_data),
        .o_err  (w_dec_err)
    );

    // Both handshake outputs decode registered state only.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_or_data;
    assign out_err   = r_or_err;
    assign err_count = r_err_count;

    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ld_or_in = 1'b0;
        w_ld_or_sk = 1'b0;
        w_ld_sk    = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next     = ONE;
                    w_ld_or_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    w_ld_or_in = 1'b1;
                end else if (w_accept) begin
                    w_next  = FULL;
                    w_ld_sk = 1'b1;
                end else if (w_deliver) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                if (w_deliver) begin
                    w_next     = ONE;
                    w_ld_or_sk = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_or_data <= '0;
            r_or_err  <= 1'b0;
            r_sk_data <= '0;
            r_sk_err  <= 1'b0;
        end else begin
            if (w_ld_or_in) begin
                r_or_data <= w_dec_data;
                r_or_err  <= w_dec_err;
            end else if (w_ld_or_sk) begin
                r_or_data <= r_sk_data;
                r_or_err  <= r_sk_err;
            end
            if (w_ld_sk) begin
                r_sk_data <= w_dec_data;
                r_sk_err  <= w_dec_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_accept && w_dec_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

endmodule
